io_port: RTL and testbench
==========================

Name: io_port

Overview:
- Peripheral-side end of the basic computer's programmed I/O interface.
- Responds to the CPU's INP/OUT/SKI/SKO/ION/IOF strobes and owns the 8-bit INPR/OUTR registers, the FGI/FGO flags and the IEN flip-flop.
- Its device side is a keyboard byte source and a printer byte sink, each with a valid/ready handshake.
- Raises the interrupt request the control unit samples to enter its interrupt cycle.

Parameters:
- PRN_DELAY, 3: cycles after a printer handshake completes before FGO is set again (0 = set on the following cycle).
- CNT_W, 4: width of the printer pacing counter. Must satisfy 2^CNT_W > PRN_DELAY.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- inp  in  1  CPU executes INP this cycle.
- out  in  1  CPU executes OUT this cycle.
- ski  in  1  CPU executes SKI this cycle.
- sko  in  1  CPU executes SKO this cycle.
- ion  in  1  CPU executes ION this cycle.
- iof  in  1  CPU executes IOF this cycle.
- irq_ack  in  1  CPU enters the interrupt cycle (R cycle); clears IEN.
- ac_low  in  8  AC[7:0] from the CPU, captured by OUT.
- inpr  out  8  INPR contents, loaded into AC[7:0] by the CPU on INP.
- skip  out  1  combinational skip condition for SKI/SKO.
- fgi  out  1  input flag.
- fgo  out  1  output flag.
- ien  out  1  interrupt enable.
- irq  out  1  registered interrupt request.
- kbd_data  in  8  keyboard byte.
- kbd_valid  in  1  keyboard byte offered.
- kbd_ready  out  1  port can accept a keyboard byte.
- prn_data  out  8  OUTR contents to the printer.
- prn_valid  out  1  printer byte offered.
- prn_ready  in  1  printer accepts the byte.

Behaviour:
- Reset (RST_N=0 at a rising edge): inpr=0, prn_data (OUTR)=0, fgi=0, fgo=1, ien=0, irq=0, prn_valid=0, pacing counter=0, printer FSM=IDLE. Reset asserted mid-transfer aborts the transfer; no byte is retained.
- Input path:
  - kbd_ready = ~fgi (combinational).
  - When kbd_valid & kbd_ready at an edge: inpr<=kbd_data, fgi<=1.
  - inp with fgi=1: fgi<=0 at that edge. inpr holds its value; the CPU samples it in the same cycle.
  - inp with fgi=0 has no effect.
  - kbd_valid while fgi=1 is not accepted; the device must hold its byte.
- Output FSM:
  - IDLE: fgo=1, prn_valid=0. out → prn_data<=ac_low, fgo<=0, go to SEND.
  - SEND: prn_valid=1 and prn_data stable until prn_ready. When prn_valid & prn_ready at an edge: counter<=PRN_DELAY and go to PACE, or go straight to IDLE if PRN_DELAY=0.
  - PACE: counter decrements each cycle; when counter==1 go to IDLE. fgo<=1 on that transition.
  - out while not IDLE (fgo=0) is ignored: OUTR unchanged, state unchanged.
- skip = (ski & fgi) | (sko & fgo), combinational, no side effects.
- Interrupt:
  - ion: ien<=1.
  - iof: ien<=0. iof beats ion if both are asserted.
  - irq_ack: ien<=0. irq_ack beats ion.
  - irq <= ien & (fgi | fgo), registered, so irq lags its inputs by 1 cycle.
- Simultaneous events:
  - inp and kbd_valid in the same cycle with fgi=1: fgi<=0, byte not accepted that cycle (kbd_ready was 0); accepted on a later edge.
  - out and prn_ready in IDLE: prn_ready ignored.
  - CPU strobes are mutually exclusive by decode. If several are asserted anyway, each acts independently, except ion/iof/irq_ack as above.
- Widths: all data 8-bit; counter CNT_W bits, never wraps (loads only at the SEND→PACE transition).

Test Plan:
- Reset with fgo=0 mid-PACE → next cycle fgi=0, fgo=1, ien=0, irq=0, prn_valid=0, inpr=0x00.
- Keyboard then INP: kbd_data=0x41 with kbd_valid → fgi=1, inpr=0x41, kbd_ready=0. Second byte 0x42 is held off. inp → fgi=0, then 0x42 is accepted.
- OUT with PRN_DELAY=3: ac_low=0x5A, out → fgo=0, prn_valid=1, prn_data=0x5A. prn_ready held low 4 cycles, then high 1 cycle → prn_valid=0; fgo=1 exactly 3 cycles after the handshake edge. A second out while fgo=0 leaves prn_data=0x5A.
- Skip: fgi=1, ski → skip=1. fgo=0, sko → skip=0. No flag changes.
- Interrupt: ion, then a keyboard byte → irq=1 one cycle after fgi=1. irq_ack → ien=0, irq=0 the following cycle. ion+iof together → ien=0.
- PRN_DELAY=0 build: handshake edge → IDLE with fgo=1 on the next cycle. Back-to-back OUTs each produce one printer handshake with the correct byte.

Source files
------------

// File: rtl/io_port.sv
// io_port: peripheral side of the basic computer's programmed I/O.
// Owns INPR/OUTR, the FGI/FGO flags and IEN. Bridges CPU I/O strobes to a
// keyboard byte source and a paced printer byte sink (valid/ready on both).
module io_port #(
    parameter int PRN_DELAY = 3,  // cycles from printer handshake to FGO set
    parameter int CNT_W     = 4   // pacing counter width, 2**CNT_W > PRN_DELAY
) (
    input  logic       CLK,
    input  logic       RST_N,
    // CPU strobes
    input  logic       inp,
    input  logic       out,
    input  logic       ski,
    input  logic       sko,
    input  logic       ion,
    input  logic       iof,
    input  logic       irq_ack,
    input  logic [7:0] ac_low,
    // CPU-visible state
    output logic [7:0] inpr,
    output logic       skip,
    output logic       fgi,
    output logic       fgo,
    output logic       ien,
    output logic       irq,
    // keyboard side
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    // printer side
    output logic [7:0] prn_data,
    output logic       prn_valid,
    input  logic       prn_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_PACE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(PRN_DELAY);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // input path state
    logic [7:0] inpr_q, inpr_d;
    logic       fgi_q, fgi_d;

    // interrupt state
    logic       ien_q, ien_d;
    logic       irq_q;

    // output path state
    state_t           state_q;
    logic [7:0]       outr_q;
    logic             fgo_q;
    logic             prn_valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic kbd_accept;

    // A keyboard byte is only taken while INPR is empty (FGI clear).
    assign kbd_ready  = ~fgi_q;
    assign kbd_accept = kbd_valid & ~fgi_q;

    // Next INPR/FGI: INP drains the flag, an accepted keyboard byte fills it.
    // Both cannot happen on one edge because acceptance requires FGI clear.
    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        if (inp && fgi_q) begin
            fgi_d = 1'b0;
        end
        if (kbd_accept) begin
            inpr_d = kbd_data;
            fgi_d  = 1'b1;
        end
    end

    // Register the input path.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            inpr_q <= 8'h00;
            fgi_q  <= 1'b0;
        end else begin
            inpr_q <= inpr_d;
            fgi_q  <= fgi_d;
        end
    end

    // Next IEN: disabling strobes (IOF, interrupt entry) win over ION.
    always_comb begin
        ien_d = ien_q;
        if (ion) begin
            ien_d = 1'b1;
        end
        if (iof || irq_ack) begin
            ien_d = 1'b0;
        end
    end

    // Register IEN and the interrupt request (one cycle behind its inputs).
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ien_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ien_q <= ien_d;
            irq_q <= ien_q & (fgi_q | fgo_q);
        end
    end

    // Printer FSM: capture OUTR on OUT, offer it until accepted, then pace
    // PRN_DELAY cycles before reporting the printer ready again via FGO.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            outr_q      <= 8'h00;
            fgo_q       <= 1'b1;
            prn_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // prn_ready is meaningless here; nothing is offered.
                    if (out) begin
                        outr_q      <= ac_low;
                        fgo_q       <= 1'b0;
                        prn_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // OUT is ignored while busy; OUTR stays stable.
                    if (prn_ready) begin
                        prn_valid_q <= 1'b0;
                        if (PRN_DELAY == 0) begin
                            fgo_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= DELAY_C;
                            state_q <= ST_PACE;
                        end
                    end
                end
                ST_PACE: begin
                    cnt_q <= cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        fgo_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    fgo_q       <= 1'b1;
                    prn_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Skip test is purely combinational and has no side effects.
    assign skip = (ski & fgi_q) | (sko & fgo_q);

    assign inpr      = inpr_q;
    assign fgi       = fgi_q;
    assign fgo       = fgo_q;
    assign ien       = ien_q;
    assign irq       = irq_q;
    assign prn_data  = outr_q;
    assign prn_valid = prn_valid_q;

endmodule

// File: tb/tb_io_port.sv
// Directed testbench for io_port: default build (PRN_DELAY=3) as dut and a
// PRN_DELAY=0 build as dut0 for the unpaced back-to-back printer case.
module tb_io_port;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       inp, out, ski, sko, ion, iof, irq_ack;
    logic [7:0] ac_low;
    logic [7:0] inpr;
    logic       skip, fgi, fgo, ien, irq;
    logic [7:0] kbd_data;
    logic       kbd_valid, kbd_ready;
    logic [7:0] prn_data;
    logic       prn_valid, prn_ready;

    // second (PRN_DELAY=0) instance
    logic       b_out;
    logic [7:0] b_ac_low;
    logic       b_prn_ready;
    logic [7:0] b_inpr, b_prn_data;
    logic       b_skip, b_fgi, b_fgo, b_ien, b_irq, b_kbd_ready, b_prn_valid;

    int n_chk  = 0;
    int n_fail = 0;
    int b_hs   = 0;

    always #5 CLK = ~CLK;

    io_port #(.PRN_DELAY(3), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .inp(inp), .out(out), .ski(ski), .sko(sko),
        .ion(ion), .iof(iof), .irq_ack(irq_ack), .ac_low(ac_low),
        .inpr(inpr), .skip(skip), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
        .prn_data(prn_data), .prn_valid(prn_valid), .prn_ready(prn_ready)
    );

    io_port #(.PRN_DELAY(0), .CNT_W(2)) dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .inp(1'b0), .out(b_out), .ski(1'b0), .sko(1'b0),
        .ion(1'b0), .iof(1'b0), .irq_ack(1'b0), .ac_low(b_ac_low),
        .inpr(b_inpr), .skip(b_skip), .fgi(b_fgi), .fgo(b_fgo), .ien(b_ien), .irq(b_irq),
        .kbd_data(8'h00), .kbd_valid(1'b0), .kbd_ready(b_kbd_ready),
        .prn_data(b_prn_data), .prn_valid(b_prn_valid), .prn_ready(b_prn_ready)
    );

    // count completed printer handshakes on the unpaced instance
    always @(posedge CLK) begin
        if (RST_N && b_prn_valid && b_prn_ready) b_hs <= b_hs + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        // load FGI, IEN and start a print so reset lands mid-PACE
        kbd_data = 8'h33; kbd_valid = 1'b1; tick(); kbd_valid = 1'b0;
        ion = 1'b1; tick(); ion = 1'b0;
        ac_low = 8'h77; out = 1'b1; tick(); out = 1'b0;
        prn_ready = 1'b1; tick(); prn_ready = 1'b0;
        tick();
        n_chk++; if (fgo !== 1'b0) begin n_fail++; $display("FAIL rst_pre_fgo got=%b exp=0", fgo); end
        RST_N = 1'b0; tick(); RST_N = 1'b1;
        n_chk++; if (fgi !== 1'b0) begin n_fail++; $display("FAIL rst_fgi got=%b exp=0", fgi); end
        n_chk++; if (fgo !== 1'b1) begin n_fail++; $display("FAIL rst_fgo got=%b exp=1", fgo); end
        n_chk++; if (ien !== 1'b0) begin n_fail++; $display("FAIL rst_ien got=%b exp=0", ien); end
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", irq); end
        n_chk++; if (prn_valid !== 1'b0) begin n_fail++; $display("FAIL rst_prn_valid got=%b exp=0", prn_valid); end
        n_chk++; if (inpr !== 8'h00) begin n_fail++; $display("FAIL rst_inpr got=%h exp=00", inpr); end
        n_chk++; if (prn_data !== 8'h00) begin n_fail++; $display("FAIL rst_outr got=%h exp=00", prn_data); end
        n_chk++; if (kbd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_kbd_ready got=%b exp=1", kbd_ready); end
        n_chk++; if (b_fgo !== 1'b1) begin n_fail++; $display("FAIL rst_b_fgo got=%b exp=1", b_fgo); end
        // aborted transfer must not resume
        tick(); tick(); tick(); tick();
        n_chk++; if (fgo !== 1'b1 || prn_valid !== 1'b0) begin n_fail++; $display("FAIL rst_abort fgo=%b pv=%b exp fgo=1 pv=0", fgo, prn_valid); end
    endtask

    task automatic test_keyboard();
        kbd_data = 8'h41; kbd_valid = 1'b1; tick();
        n_chk++; if (fgi !== 1'b1) begin n_fail++; $display("FAIL kbd_fgi1 got=%b exp=1", fgi); end
        n_chk++; if (inpr !== 8'h41) begin n_fail++; $display("FAIL kbd_inpr1 got=%h exp=41", inpr); end
        n_chk++; if (kbd_ready !== 1'b0) begin n_fail++; $display("FAIL kbd_ready_full got=%b exp=0", kbd_ready); end
        kbd_data = 8'h42; tick();
        n_chk++; if (inpr !== 8'h41) begin n_fail++; $display("FAIL kbd_holdoff got=%h exp=41", inpr); end
        // INP and a pending byte on the same edge: flag clears, byte waits
        inp = 1'b1; tick(); inp = 1'b0;
        n_chk++; if (fgi !== 1'b0) begin n_fail++; $display("FAIL kbd_inp_clr got=%b exp=0", fgi); end
        n_chk++; if (inpr !== 8'h41) begin n_fail++; $display("FAIL kbd_inp_hold got=%h exp=41", inpr); end
        n_chk++; if (kbd_ready !== 1'b1) begin n_fail++; $display("FAIL kbd_ready_empty got=%b exp=1", kbd_ready); end
        tick(); kbd_valid = 1'b0;
        n_chk++; if (fgi !== 1'b1 || inpr !== 8'h42) begin n_fail++; $display("FAIL kbd_second fgi=%b inpr=%h exp 1/42", fgi, inpr); end
        inp = 1'b1; tick();
        n_chk++; if (fgi !== 1'b0) begin n_fail++; $display("FAIL kbd_inp2 got=%b exp=0", fgi); end
        tick(); inp = 1'b0;
        n_chk++; if (fgi !== 1'b0 || inpr !== 8'h42) begin n_fail++; $display("FAIL kbd_inp_empty fgi=%b inpr=%h exp 0/42", fgi, inpr); end
    endtask

    task automatic test_output();
        ac_low = 8'h5A; out = 1'b1; tick(); out = 1'b0;
        n_chk++; if (fgo !== 1'b0) begin n_fail++; $display("FAIL out_fgo got=%b exp=0", fgo); end
        n_chk++; if (prn_valid !== 1'b1) begin n_fail++; $display("FAIL out_valid got=%b exp=1", prn_valid); end
        n_chk++; if (prn_data !== 8'h5A) begin n_fail++; $display("FAIL out_data got=%h exp=5A", prn_data); end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin ac_low = 8'hA5; out = 1'b1; end
            tick(); out = 1'b0;
            n_chk++; if (prn_valid !== 1'b1 || prn_data !== 8'h5A) begin n_fail++; $display("FAIL out_wait%0d pv=%b data=%h exp 1/5A", i, prn_valid, prn_data); end
        end
        prn_ready = 1'b1; tick(); prn_ready = 1'b0;
        n_chk++; if (prn_valid !== 1'b0) begin n_fail++; $display("FAIL out_hs_valid got=%b exp=0", prn_valid); end
        n_chk++; if (fgo !== 1'b0) begin n_fail++; $display("FAIL out_pace0 got=%b exp=0", fgo); end
        tick();
        n_chk++; if (fgo !== 1'b0) begin n_fail++; $display("FAIL out_pace1 got=%b exp=0", fgo); end
        tick();
        n_chk++; if (fgo !== 1'b0) begin n_fail++; $display("FAIL out_pace2 got=%b exp=0", fgo); end
        tick();
        n_chk++; if (fgo !== 1'b1) begin n_fail++; $display("FAIL out_pace3 got=%b exp=1", fgo); end
        n_chk++; if (prn_data !== 8'h5A) begin n_fail++; $display("FAIL out_outr_kept got=%h exp=5A", prn_data); end
        // OUT with prn_ready already high in IDLE: the ready is not a handshake
        ac_low = 8'hC3; out = 1'b1; prn_ready = 1'b1; tick(); out = 1'b0;
        n_chk++; if (prn_valid !== 1'b1 || prn_data !== 8'hC3) begin n_fail++; $display("FAIL out_idle_rdy pv=%b data=%h exp 1/C3", prn_valid, prn_data); end
        tick(); prn_ready = 1'b0;
        n_chk++; if (prn_valid !== 1'b0) begin n_fail++; $display("FAIL out_idle_hs got=%b exp=0", prn_valid); end
        tick(); tick(); tick();
        n_chk++; if (fgo !== 1'b1) begin n_fail++; $display("FAIL out_idle_done got=%b exp=1", fgo); end
    endtask

    task automatic test_skip();
        kbd_data = 8'h10; kbd_valid = 1'b1; tick(); kbd_valid = 1'b0;
        ski = 1'b1; #1;
        n_chk++; if (skip !== 1'b1) begin n_fail++; $display("FAIL skip_ski got=%b exp=1", skip); end
        ski = 1'b0;
        ac_low = 8'h01; out = 1'b1; tick(); out = 1'b0;
        sko = 1'b1; #1;
        n_chk++; if (skip !== 1'b0) begin n_fail++; $display("FAIL skip_sko_busy got=%b exp=0", skip); end
        ski = 1'b1; tick();
        n_chk++; if (fgi !== 1'b1 || fgo !== 1'b0) begin n_fail++; $display("FAIL skip_noeffect fgi=%b fgo=%b exp 1/0", fgi, fgo); end
        ski = 1'b0; sko = 1'b0;
        prn_ready = 1'b1; tick(); prn_ready = 1'b0;
        tick(); tick(); tick();
        sko = 1'b1; #1;
        n_chk++; if (skip !== 1'b1) begin n_fail++; $display("FAIL skip_sko_rdy got=%b exp=1", skip); end
        sko = 1'b0;
        inp = 1'b1; tick(); inp = 1'b0;
    endtask

    task automatic test_interrupt();
        // hold FGO low so only FGI can raise the request
        ac_low = 8'h02; out = 1'b1; tick(); out = 1'b0;
        ion = 1'b1; tick(); ion = 1'b0;
        n_chk++; if (ien !== 1'b1) begin n_fail++; $display("FAIL irq_ion got=%b exp=1", ien); end
        tick();
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_noflag got=%b exp=0", irq); end
        kbd_data = 8'h55; kbd_valid = 1'b1; tick(); kbd_valid = 1'b0;
        n_chk++; if (fgi !== 1'b1 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag fgi=%b irq=%b exp 1/0", fgi, irq); end
        tick();
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise got=%b exp=1", irq); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_chk++; if (ien !== 1'b0) begin n_fail++; $display("FAIL irq_ack_ien got=%b exp=0", ien); end
        tick();
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ack_irq got=%b exp=0", irq); end
        ion = 1'b1; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_chk++; if (ien !== 1'b0) begin n_fail++; $display("FAIL irq_ack_beats_ion got=%b exp=0", ien); end
        iof = 1'b1; tick(); iof = 1'b0;
        n_chk++; if (ien !== 1'b0) begin n_fail++; $display("FAIL irq_iof_beats_ion got=%b exp=0", ien); end
        tick(); ion = 1'b0;
        n_chk++; if (ien !== 1'b1) begin n_fail++; $display("FAIL irq_ion_again got=%b exp=1", ien); end
        iof = 1'b1; tick(); iof = 1'b0;
        n_chk++; if (ien !== 1'b0) begin n_fail++; $display("FAIL irq_iof got=%b exp=0", ien); end
        inp = 1'b1; tick(); inp = 1'b0;
        prn_ready = 1'b1; tick(); prn_ready = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int hs0;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        hs0 = b_hs;
        b_prn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_ac_low = bytes[i]; b_out = 1'b1; tick(); b_out = 1'b0;
            n_chk++; if (b_prn_valid !== 1'b1 || b_prn_data !== bytes[i] || b_fgo !== 1'b0) begin n_fail++; $display("FAIL b2b_send%0d pv=%b data=%h fgo=%b exp 1/%h/0", i, b_prn_valid, b_prn_data, b_fgo, bytes[i]); end
            tick();
            n_chk++; if (b_prn_valid !== 1'b0 || b_fgo !== 1'b1) begin n_fail++; $display("FAIL b2b_done%0d pv=%b fgo=%b exp 0/1", i, b_prn_valid, b_fgo); end
        end
        b_prn_ready = 1'b0;
        tick();
        n_chk++; if (b_hs - hs0 !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", b_hs - hs0); end
    endtask

    initial begin
        RST_N = 1'b0;
        inp = 1'b0; out = 1'b0; ski = 1'b0; sko = 1'b0;
        ion = 1'b0; iof = 1'b0; irq_ack = 1'b0; ac_low = 8'h00;
        kbd_data = 8'h00; kbd_valid = 1'b0; prn_ready = 1'b0;
        b_out = 1'b0; b_ac_low = 8'h00; b_prn_ready = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        tick();
        test_reset();
        test_keyboard();
        test_output();
        test_skip();
        test_interrupt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
